axis_pix_rx: RTL and testbench
==============================

Name: axis_pix_rx

Overview:
- AXI4-Stream slave at the front of the edge-detection pipeline. Accepts 8-bit gray pixels from the DMA (MM2S) channel.
- Buffers the pixels in a small FIFO and re-issues them as a pixel-enable strobe plus data for the gradient/NMS/dual-threshold chain.
- Tracks column and row position within the frame.
- Checks that TLAST arrives at every BURST_LEN-beat boundary, matching the burst framing used on the output stream.

Parameters:
- DATA_W, 8, pixel width in bits.
- LINE_W, 1024, pixels per line.
- FRAME_LINES, 1024, lines per frame.
- BURST_LEN, 128, beats per DMA burst; TLAST is expected on the last beat of each burst.
- FIFO_DEPTH, 16, FIFO entries; must be a power of 2, minimum 4.

Ports:
- clk, input, 1, single clock.
- rst, input, 1, asynchronous, active-high reset.
- s_axis_tdata, input, DATA_W, pixel data.
- s_axis_tvalid, input, 1, upstream beat valid.
- s_axis_tready, output, 1, block can accept a beat.
- s_axis_tlast, input, 1, end of burst.
- stall, input, 1, downstream pause; no pixel is issued while it is high.
- pix_en, output, 1, one-cycle pixel strobe (drives the pipeline en).
- pix_data, output, DATA_W, pixel value qualified by pix_en.
- col, output, 11, column of the current pix_data, range 0..LINE_W-1.
- row, output, 11, row of the current pix_data, range 0..FRAME_LINES-1.
- line_start, output, 1, high with pix_en when col==0.
- frame_end, output, 1, high with pix_en on the pixel at col==LINE_W-1 and row==FRAME_LINES-1.
- err_last, output, 1, sticky TLAST framing error.
- err_clr, input, 1, synchronous clear of err_last.

Behaviour:
- Reset values (rst high, asynchronous): s_axis_tready=0, pix_en=0, pix_data=0, col=0, row=0, line_start=0, frame_end=0, err_last=0. FIFO is emptied and the beat counter is cleared.
- s_axis_tready = ~full, decoded from the registered FIFO count. It is 0 during reset and 1 from the first clk edge after rst deasserts.
- A beat is accepted on a rising edge with tvalid && tready. tready is never combinationally dependent on tvalid.
- FIFO:
  - Write pointer, read pointer and count are each log2(FIFO_DEPTH)+1 bits wide.
  - Simultaneous push and pop leaves count unchanged.
  - There is no bypass path. Push is blocked when full because tready is 0. Pop is blocked when empty.
- Pop rule: pop on an edge where count!=0 and stall==0.
- Output register: on a pop, the head entry is registered into pix_data and pix_en=1 for exactly one cycle. Otherwise pix_en=0 and pix_data holds its value.
- Latency: a beat accepted at edge T0 into an empty FIFO, with stall low at T1, appears as pix_en=1 between T1 and T2. Sustained throughput is 1 pixel per cycle.
- Stall is sampled at the edge. If stall is high at edge Tn, no pop occurs at Tn.
- Position counters advance on each issued pixel; col/row describe the pixel currently on pix_data.
  - col wraps from LINE_W-1 to 0, and row then increments.
  - row wraps from FRAME_LINES-1 to 0 after the frame_end pixel.
  - Arithmetic is plain unsigned on 11 bits with explicit wrap compares.
- TLAST check:
  - beat_cnt (log2(BURST_LEN) bits) increments on each accepted beat.
  - Error condition A: an accepted beat has tlast=1 and beat_cnt!=BURST_LEN-1.
  - Error condition B: an accepted beat has tlast=0 and beat_cnt==BURST_LEN-1.
  - Either condition sets err_last.
  - Any accepted beat with tlast=1 resyncs beat_cnt to 0; otherwise beat_cnt wraps naturally.
  - The data of a beat that triggers an error is still stored and issued.
- err_last clears only when err_clr is high on an edge. If a set event and err_clr occur on the same edge, set wins.
- Mid-operation reset discards all buffered pixels and clears all positions. There are no partial-frame semantics; upstream must restart the frame.
- The block has no knowledge of frame boundaries on the input side; alignment relies on the DMA starting at pixel (0,0) after reset.

Test Plan:
- Reset, then stream 256 beats with tvalid constant, stall=0, tlast on beats 127 and 255 -> 256 pix_en pulses in 256 consecutive cycles, first pulse 1 cycle after first acceptance; pix_data equals input order; err_last=0; col ends at 255, row=0.
- Hold stall=1 while sending 20 beats -> tready drops after exactly 16 accepts; no pix_en. Release stall -> 16 pixels drain in order, then the remaining 4 are accepted and issued; no data is lost or duplicated.
- Full frame, LINE_W=1024 and FRAME_LINES=1024, with random tvalid gaps and random stall -> line_start pulses 1024 times; frame_end pulses exactly once, on pixel 1048575 with col=1023, row=1023; the next pixel has col=0, row=0.
- tlast on beat 100 (early) -> err_last=1 on the following cycle; beat_cnt resyncs, so tlast on beat 228 raises no new error; err_clr pulse -> err_last=0.
- Omit tlast on beat 127 -> err_last set. Assert err_clr on the same edge as a new error event -> err_last stays 1.
- Assert rst for one cycle mid-frame with FIFO holding 10 entries -> pix_en=0, col=row=0, tready low during reset, FIFO empty afterwards; the next accepted beat is issued with col=0, row=0.

Source files
------------

// File: rtl/axis_pix_rx.sv
// AXI4-Stream pixel receiver: buffers gray pixels in a small FIFO, reissues them
// as a pixel strobe with frame position, and checks TLAST burst framing.
module axis_pix_rx #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned LINE_W      = 1024,
   parameter int unsigned FRAME_LINES = 1024,
   parameter int unsigned BURST_LEN   = 128,
   parameter int unsigned FIFO_DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic              s_axis_tlast,
   input  logic              stall,
   output logic              pix_en,
   output logic [DATA_W-1:0] pix_data,
   output logic [10:0]       col,
   output logic [10:0]       row,
   output logic              line_start,
   output logic              frame_end,
   output logic              err_last,
   input  logic              err_clr
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned BW = $clog2(BURST_LEN);

   localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
   localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
   localparam logic [10:0]   LAST_COL  = 11'(LINE_W - 1);
   localparam logic [10:0]   LAST_ROW  = 11'(FRAME_LINES - 1);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic [AW:0]       count;
   logic              run;
   logic              push;
   logic              pop;
   logic [10:0]       nxt_col;
   logic [10:0]       nxt_row;
   logic [BW-1:0]     beat_cnt;
   logic              last_slot;
   logic              frame_err;

   // run keeps tready low until the first edge after reset is released
   assign s_axis_tready = run && (count != FULL_CNT);
   assign push          = s_axis_tvalid && s_axis_tready;
   assign pop           = (count != '0) && !stall;
   assign last_slot     = (beat_cnt == LAST_BEAT);
   // TLAST must coincide exactly with the last beat slot of a burst
   assign frame_err     = push && (s_axis_tlast != last_slot);

   // Ready enable after reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run <= 1'b0;
      end else begin
         run <= 1'b1;
      end
   end

   // FIFO storage, no reset needed since count qualifies every entry
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + PTR_ONE;
            2'b01:   count <= count - PTR_ONE;
            default: count <= count;
         endcase
      end
   end

   // Output register: one-cycle strobe per popped pixel, data holds otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_en   <= 1'b0;
         pix_data <= '0;
      end else begin
         pix_en <= pop;
         if (pop) begin
            pix_data <= mem[rd_ptr[AW-1:0]];
         end
      end
   end

   // Position tracking: nxt_* is where the next issued pixel lands, col/row
   // describe the pixel currently on pix_data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nxt_col    <= '0;
         nxt_row    <= '0;
         col        <= '0;
         row        <= '0;
         line_start <= 1'b0;
         frame_end  <= 1'b0;
      end else if (pop) begin
         col        <= nxt_col;
         row        <= nxt_row;
         line_start <= (nxt_col == '0);
         frame_end  <= (nxt_col == LAST_COL) && (nxt_row == LAST_ROW);
         if (nxt_col == LAST_COL) begin
            nxt_col <= '0;
            nxt_row <= (nxt_row == LAST_ROW) ? '0 : nxt_row + 11'd1;
         end else begin
            nxt_col <= nxt_col + 11'd1;
         end
      end else begin
         line_start <= 1'b0;
         frame_end  <= 1'b0;
      end
   end

   // Burst beat counter, resynchronised by any accepted TLAST
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt <= '0;
      end else if (push) begin
         beat_cnt <= s_axis_tlast ? '0 : beat_cnt + BEAT_ONE;
      end
   end

   // Sticky framing error; a new error wins over a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_last <= 1'b0;
      end else if (frame_err) begin
         err_last <= 1'b1;
      end else if (err_clr) begin
         err_last <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axis_pix_rx.sv
// Randomised bench for axis_pix_rx with a queue-based reference model.
module tb_axis_pix_rx;

   localparam int DATA_W      = 8;
   localparam int LINE_W      = 64;
   localparam int FRAME_LINES = 8;
   localparam int BURST_LEN   = 128;
   localparam int FIFO_DEPTH  = 16;
   localparam int FRAME_PIX   = LINE_W * FRAME_LINES;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [DATA_W-1:0] tdata = '0;
   logic              tvalid = 1'b0;
   logic              tlast = 1'b0;
   logic              stall = 1'b0;
   logic              err_clr = 1'b0;
   logic              tready;
   logic              pix_en;
   logic [DATA_W-1:0] pix_data;
   logic [10:0]       col;
   logic [10:0]       row;
   logic              line_start;
   logic              frame_end;
   logic              err_last;

   axis_pix_rx #(
      .DATA_W      (DATA_W),
      .LINE_W      (LINE_W),
      .FRAME_LINES (FRAME_LINES),
      .BURST_LEN   (BURST_LEN),
      .FIFO_DEPTH  (FIFO_DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (tdata),
      .s_axis_tvalid (tvalid),
      .s_axis_tready (tready),
      .s_axis_tlast  (tlast),
      .stall         (stall),
      .pix_en        (pix_en),
      .pix_data      (pix_data),
      .col           (col),
      .row           (row),
      .line_start    (line_start),
      .frame_end     (frame_end),
      .err_last      (err_last),
      .err_clr       (err_clr)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: pixels accepted but not yet issued, in arrival order
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] exp_d;
   int  pix_idx   = 0;    // pixels issued since reset
   int  burst_pos = 0;    // beats since the last TLAST
   bit  exp_en    = 1'b0;
   bit  err_exp   = 1'b0;
   bit  run_seen  = 1'b0;
   bit  bad_beat;
   int  n_issued  = 0;
   int  n_acc     = 0;
   int  n_ls      = 0;
   int  n_fe      = 0;
   bit  rand_stall = 1'b0;

   // Observe outputs of the last edge, then predict the next edge
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         pix_idx   = 0;
         burst_pos = 0;
         exp_en    = 1'b0;
         err_exp   = 1'b0;
         run_seen  = 1'b0;
      end else begin
         check_eq("pix_en", pix_en, exp_en);
         n_issued += int'(pix_en);
         n_ls     += int'(line_start);
         n_fe     += int'(frame_end);
         if (exp_en) begin
            exp_d = exp_q.pop_front();
            check_eq("pix_data", pix_data, exp_d);
            check_eq("col", col, pix_idx % LINE_W);
            check_eq("row", row, (pix_idx / LINE_W) % FRAME_LINES);
            check_eq("line_start", line_start, (pix_idx % LINE_W) == 0);
            check_eq("frame_end", frame_end, (pix_idx % FRAME_PIX) == FRAME_PIX - 1);
            pix_idx++;
         end
         check_eq("err_last", err_last, err_exp);
         if (run_seen) check_eq("tready", tready, exp_q.size() < FIFO_DEPTH);
         run_seen = 1'b1;
         exp_en = (exp_q.size() > 0) && !stall;
         if (tvalid && tready) begin
            n_acc++;
            exp_q.push_back(tdata);
            bad_beat  = (tlast != 1'b0) != (burst_pos == BURST_LEN - 1);
            err_exp   = bad_beat ? 1'b1 : (err_clr ? 1'b0 : err_exp);
            burst_pos = tlast ? 0 : (burst_pos + 1) % BURST_LEN;
         end else if (err_clr) begin
            err_exp = 1'b0;
         end
      end
   end

   // Send n beats; TLAST on every burst boundary except skip, plus on early
   task automatic send(input int n, input int early, input int skip, input bit gaps);
      int  waitc;
      bit  acc;
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               tvalid = 1'b0;
               if (rand_stall) stall = ($urandom_range(0, 3) == 0);
               @(posedge clk); #1;
            end
         end
         tvalid = 1'b1;
         tdata  = DATA_W'($urandom);
         tlast  = (i == early) || ((i % BURST_LEN == BURST_LEN - 1) && (i != skip));
         waitc  = 0;
         acc    = 1'b0;
         while (!acc && waitc < 500) begin
            if (rand_stall) stall = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            acc = tready;
            @(posedge clk); #1;
            waitc++;
         end
         if (!acc) check_eq("accept_timeout", 0, 1);
         tvalid = 1'b0;
         tlast  = 1'b0;
      end
   endtask

   // Wait until every accepted pixel has been issued and observed
   task automatic drain();
      int  c;
      stall = 1'b0;
      c = 0;
      while ((exp_q.size() != 0 || exp_en) && c < 300) begin
         @(posedge clk); #1;
         c++;
      end
      if (c >= 300) check_eq("drain_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   int acc0;
   int iss0;

   initial begin
      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_tready", tready, 0);
      check_eq("rst_pix_en", pix_en, 0);
      check_eq("rst_pix_data", pix_data, 0);
      check_eq("rst_col", col, 0);
      check_eq("rst_row", row, 0);
      check_eq("rst_line_start", line_start, 0);
      check_eq("rst_frame_end", frame_end, 0);
      check_eq("rst_err_last", err_last, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Back-to-back stream of two bursts
      send(256, -1, -1, 1'b0);
      drain();
      check_eq("t1_issued", n_issued, 256);
      check_eq("t1_err", err_last, 0);
      check_eq("t1_col", col, 255 % LINE_W);
      check_eq("t1_row", row, (255 / LINE_W) % FRAME_LINES);

      // Early TLAST, then a clean burst after resync
      send(101, 100, -1, 1'b0);
      check_eq("t4_err_set", err_last, 1);
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      check_eq("t4_err_clr", err_last, 0);
      send(128, -1, -1, 1'b0);
      drain();
      check_eq("t4_no_new_err", err_last, 0);

      // Missing TLAST, then clear colliding with a new error
      send(128, -1, 127, 1'b0);
      check_eq("t5_err_set", err_last, 1);
      drain();
      tvalid  = 1'b1;
      tdata   = DATA_W'($urandom);
      tlast   = 1'b1;
      err_clr = 1'b1;
      @(posedge clk); #1;
      tvalid  = 1'b0;
      tlast   = 1'b0;
      err_clr = 1'b0;
      check_eq("t5_set_wins", err_last, 1);
      drain();

      // Stall while 20 beats are offered
      acc0 = n_acc;
      iss0 = n_issued;
      stall = 1'b1;
      fork
         send(20, -1, -1, 1'b0);
         begin
            repeat (30) @(posedge clk);
            #1;
            check_eq("t2_accepts", n_acc - acc0, 16);
            check_eq("t2_tready_low", tready, 0);
            check_eq("t2_no_issue", n_issued - iss0, 0);
            stall = 1'b0;
         end
      join
      drain();
      check_eq("t2_issued", n_issued - iss0, 20);

      // Full frame plus one pixel with random gaps and stalls
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      n_ls = 0;
      n_fe = 0;
      rand_stall = 1'b1;
      send(FRAME_PIX + 1, -1, -1, 1'b1);
      rand_stall = 1'b0;
      drain();
      check_eq("t3_line_starts", n_ls, FRAME_LINES + 1);
      check_eq("t3_frame_ends", n_fe, 1);
      check_eq("t3_wrap_col", col, 0);
      check_eq("t3_wrap_row", row, 0);

      // Reset with 10 buffered pixels
      stall = 1'b1;
      send(10, -1, -1, 1'b0);
      check_eq("t6_pre_tready", tready, 1);
      rst = 1'b1;
      #1;
      check_eq("t6_rst_tready", tready, 0);
      check_eq("t6_rst_pix_en", pix_en, 0);
      check_eq("t6_rst_col", col, 0);
      check_eq("t6_rst_row", row, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      stall = 1'b0;
      iss0 = n_issued;
      repeat (5) @(posedge clk);
      #1;
      check_eq("t6_empty", n_issued - iss0, 0);
      send(1, -1, -1, 1'b0);
      drain();
      check_eq("t6_one_issued", n_issued - iss0, 1);
      check_eq("t6_col", col, 0);
      check_eq("t6_row", row, 0);
      check_eq("t6_err", err_last, 0);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
